// File: rtl/imem_stream_pkg.sv
// Shared framing constants and FSM state encoding for the program-stream
// transmitter and its loader-side counterpart.
package imem_stream_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hFE;
  localparam logic [7:0] EOF_BYTE = 8'hFF;
  localparam logic [7:0] PAD_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_FETCH,
    ST_DATA,
    ST_EOF,
    ST_PAD,
    ST_DONE
  } tx_state_e;

  // True when any byte of a word collides with the EOF marker.
  function automatic logic has_ff(input logic [31:0] w);
    return (w[31:24] == EOF_BYTE) || (w[23:16] == EOF_BYTE) ||
           (w[15:8]  == EOF_BYTE) || (w[7:0]   == EOF_BYTE);
  endfunction

endpackage

// File: rtl/imem_tx_strobe_gen.sv
// Byte window timer: strobe high for STB_HI cycles, then low for STB_LO,
// with byte_done marking the last cycle of each window. Holds at phase 0
// while run is low so the next window always starts from its high phase.
module imem_tx_strobe_gen #(
  parameter int STB_HI = 2,
  parameter int STB_LO = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic stb,
  output logic byte_done
);

  localparam int CW = 5;
  localparam logic [CW-1:0] HI_CNT = CW'(STB_HI);
  localparam logic [CW-1:0] LAST   = CW'(STB_HI + STB_LO - 1);

  logic [CW-1:0] cnt;

  // Phase counter wraps at the end of each window, back-to-back windows abut.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  cnt <= '0;
    else if (!run || cnt == LAST)  cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  assign stb       = run && (cnt < HI_CNT);
  assign byte_done = run && (cnt == LAST);

endmodule

// File: rtl/imem_byte_tx.sv
// Streams a program buffer as a byte frame: SOF, 4 bytes per word MSB
// first, EOF, PAD. Optional build macro IMEM_TX_FF_CHECK_EN aborts the
// frame (EOF+PAD, err_o instead of done_o) on a fetched word containing 0xFF.
module imem_byte_tx
  import imem_stream_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int STB_HI = 2,
  parameter int STB_LO = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   word_cnt_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       rd_data_i,
  output logic [7:0]        byte_o,
  output logic              byte_stb_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  tx_state_e         state, nxt;
  logic [ADDR_W:0]   word_left;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_idx;
  logic [31:0]       shreg;
  logic              run, byte_done, word_bad;

`ifdef IMEM_TX_FF_CHECK_EN
  logic err_q;
  assign word_bad = has_ff(rd_data_i);
`else
  assign word_bad = 1'b0;
`endif

  assign run = (state == ST_SOF) || (state == ST_DATA) ||
               (state == ST_EOF) || (state == ST_PAD);

  imem_tx_strobe_gen #(.STB_HI(STB_HI), .STB_LO(STB_LO)) u_stb (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .stb       (byte_stb_o),
    .byte_done (byte_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  // Next-state: byte states advance on window end, FETCH is a single cycle.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start_i) nxt = ST_SOF;
      ST_SOF:   if (byte_done) nxt = (word_left != '0) ? ST_FETCH : ST_EOF;
      ST_FETCH: nxt = word_bad ? ST_EOF : ST_DATA;
      ST_DATA:  if (byte_done && byte_idx == 2'd3)
                  nxt = (word_left != '0) ? ST_FETCH : ST_EOF;
      ST_EOF:   if (byte_done) nxt = ST_PAD;
      ST_PAD:   if (byte_done) nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Word/byte bookkeeping; the address only advances when another word
  // follows, so it never wraps even for a full 2^ADDR_W-word frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_left <= '0;
      addr      <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start_i) begin
          word_left <= word_cnt_i;
          addr      <= '0;
          byte_idx  <= '0;
        end
        ST_FETCH: begin
          shreg     <= rd_data_i;
          word_left <= word_left - 1'b1;
          byte_idx  <= '0;
          if (word_left > (ADDR_W+1)'(1)) addr <= addr + 1'b1;
        end
        ST_DATA: if (byte_done) begin
          shreg    <= {shreg[23:0], 8'h00};
          byte_idx <= byte_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_TX_FF_CHECK_EN
  // Abort flag, latched on a bad word and cleared at the next accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           err_q <= 1'b0;
    else if (state == ST_IDLE && start_i)   err_q <= 1'b0;
    else if (state == ST_FETCH && word_bad) err_q <= 1'b1;
  end
  assign done_o = (state == ST_DONE) && !err_q;
  assign err_o  = (state == ST_DONE) &&  err_q;
`else
  assign done_o = (state == ST_DONE);
  assign err_o  = 1'b0;
`endif

  // Byte mux: held for the whole window, zero outside byte states.
  always_comb begin
    byte_o = 8'h00;
    case (state)
      ST_SOF:  byte_o = SOF_BYTE;
      ST_DATA: byte_o = shreg[31:24];
      ST_EOF:  byte_o = EOF_BYTE;
      ST_PAD:  byte_o = PAD_BYTE;
      default: byte_o = 8'h00;
    endcase
  end

  assign rd_addr_o = addr;
  assign busy_o    = (state != ST_IDLE) && (state != ST_DONE);

endmodule

// File: tb/tb_imem_byte_tx.sv
// Scoreboard bench for imem_byte_tx: stimulus pushes expected bytes, a
// negedge monitor pops one per strobe rising edge.
module tb_imem_byte_tx;
  localparam int ADDR_W = 6;
  localparam int STB_HI = 2;
  localparam int STB_LO = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W:0]   word_cnt_i = '0;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [31:0]       rd_data_i;
  logic [7:0]        byte_o;
  logic              byte_stb_o, busy_o, done_o, err_o;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int n_cmp = 0, n_bad = 0;
  int stb_cnt = 0, done_cnt = 0, err_cnt = 0;
  int addr_chg = 0, wrap_cnt = 0, addr_max = 0;
  logic stb_prev = 1'b0;
  logic [ADDR_W-1:0] addr_prev = '0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  imem_byte_tx #(.ADDR_W(ADDR_W), .STB_HI(STB_HI), .STB_LO(STB_LO)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .word_cnt_i(word_cnt_i),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .byte_o(byte_o),
    .byte_stb_o(byte_stb_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data_i <= mem[rd_addr_o];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on each strobe rise, pulse and address tracking.
  always @(negedge clk) begin
    if (reset_n) begin
      if (byte_stb_o && !stb_prev) begin
        stb_cnt++;
        rx_q.push_back(byte_o);
        if (exp_q.size() == 0) chk("unexpected_byte", {56'd1, byte_o}, {56'd0, byte_o});
        else chk("byte", byte_o, exp_q.pop_front());
      end
      if (done_o) done_cnt++;
      if (err_o)  err_cnt++;
      if (busy_o) begin
        if (rd_addr_o != addr_prev) addr_chg++;
        if (rd_addr_o <  addr_prev) wrap_cnt++;
        if (int'(rd_addr_o) > addr_max) addr_max = int'(rd_addr_o);
        addr_prev = rd_addr_o;
      end
    end
    stb_prev = byte_stb_o;
  end

  task automatic push_frame(input int n);
    exp_q.push_back(8'hFE);
    for (int w = 0; w < n; w++) begin
      logic [31:0] v;
      v = mem[w];
      exp_q.push_back(v[31:24]); exp_q.push_back(v[23:16]);
      exp_q.push_back(v[15:8]);  exp_q.push_back(v[7:0]);
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
  endtask

  task automatic run_frame(input string nm, input int n, input int exp_len,
                           input bit exp_done, input int inject_at);
    int d0, e0, s0, nexp, cyc;
    nexp = exp_q.size(); d0 = done_cnt; e0 = err_cnt; s0 = stb_cnt;
    rx_q.delete();
    @(negedge clk);
    addr_prev = '0; addr_chg = 0; wrap_cnt = 0; addr_max = 0;
    word_cnt_i = (ADDR_W+1)'(n);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk({nm, " busy_rise"}, busy_o, 1);
    cyc = 0;
    while (!(done_o || err_o) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start_i = (cyc == inject_at);
    end
    start_i = 1'b0;
    chk({nm, " frame_len"}, cyc, exp_len);
    chk({nm, " busy_in_done"}, busy_o, 0);
    repeat (20) @(negedge clk);
    chk({nm, " done_pulses"}, done_cnt - d0, exp_done ? 1 : 0);
    chk({nm, " err_pulses"}, err_cnt - e0, exp_done ? 0 : 1);
    chk({nm, " strobes"}, stb_cnt - s0, nexp);
    chk({nm, " queue_left"}, exp_q.size(), 0);
    chk({nm, " idle_busy"}, busy_o, 0);
  endtask

  initial begin
    int s0, cyc;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'(i);

    #1;
    chk("reset_outputs", {rd_addr_o, byte_o, byte_stb_o, busy_o, done_o, err_o}, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {byte_o, byte_stb_o, busy_o}, 0);

    // Empty frame: FE FF 00, 12 cycles, address untouched.
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    run_frame("empty", 0, 12, 1'b1, -1);
    chk("empty addr_changes", addr_chg, 0);

    // One word.
    mem[0] = 32'h12345678;
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    run_frame("one_word", 1, 29, 1'b1, -1);

    // Full buffer: 64 words, address sweep without wrap, loader rebuild.
    mem[0] = 32'h0;
    push_frame(64);
    run_frame("full", 64, 1100, 1'b1, -1);
    chk("full addr_max", addr_max, 63);
    chk("full addr_wrap", wrap_cnt, 0);
    chk("full rx_len", rx_q.size(), 259);
    if (rx_q.size() == 259) begin
      for (int i = 0; i < 64; i++)
        chk("loader_word", {rx_q[1+4*i], rx_q[2+4*i], rx_q[3+4*i], rx_q[4+4*i]}, 32'(i));
    end

    // Reset during word 2 byte 1.
    mem[0] = 32'h01020304; mem[1] = 32'h05060708; mem[2] = 32'h090A0B0C;
    push_frame(3);
    s0 = stb_cnt;
    @(negedge clk);
    word_cnt_i = 7'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while ((stb_cnt - s0) < 11 && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("rst reach_w2b1", stb_cnt - s0, 11);
    chk("rst addr_before", rd_addr_o, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("rst outputs_zero", {rd_addr_o, byte_o, byte_stb_o, busy_o, done_o, err_o}, 0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    mem[0] = 32'h12345678;
    push_frame(1);
    run_frame("restart", 1, 29, 1'b1, -1);

    // Start pulsed mid-frame must be ignored.
    mem[0] = 32'hCAFEBABE; mem[1] = 32'hDEADBEEF;
    push_frame(2);
    run_frame("start_busy", 2, 46, 1'b1, 20);

    // Word containing 0xFF.
    mem[0] = 32'hA1B2C3D4; mem[1] = 32'h00FF0000; mem[2] = 32'h11223344;
`ifdef IMEM_TX_FF_CHECK_EN
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    run_frame("ff_abort", 3, 30, 1'b0, -1);
`else
    push_frame(3);
    run_frame("ff_verbatim", 3, 63, 1'b1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_byte_tx.md
IMEM_BYTE_TX -- requirements
Module: imem_byte_tx

Interface
REQ-001 Parameter ADDR_W, default 6: word address width; maximum program length is 2^ADDR_W words.
REQ-002 Parameter STB_HI, default 2: clock cycles that byte_stb_o is held high per byte (legal range 1..15).
REQ-003 Parameter STB_LO, default 2: clock cycles that byte_stb_o is held low after each high phase (legal range 1..15).
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  one-cycle request to stream a program; ignored while busy_o=1.
REQ-007 word_cnt_i  input  ADDR_W+1  number of words to send (0..2^ADDR_W), sampled with start_i.
REQ-008 rd_addr_o  output  ADDR_W  word address to the program buffer.
REQ-009 rd_data_i  input  32  buffer read data, valid one cycle after rd_addr_o (synchronous read).
REQ-010 byte_o  output  8  stream byte, stable for the whole high+low window of its strobe.
REQ-011 byte_stb_o  output  1  byte strobe; the receiver samples byte_o on its rising edge.
REQ-012 busy_o  output  1  high from the cycle after start acceptance until the stream completes.
REQ-013 done_o  output  1  one-cycle pulse on completion.
REQ-014 err_o  output  1  one-cycle pulse on abort (only when IMEM_TX_FF_CHECK_EN is defined).

Function
REQ-015 The frame SHALL be 0xFE (SOF), then 4*word_cnt data bytes, then 0xFF (EOF), then 0x00 (PAD); PAD clears the receiver's load flag.
REQ-016 Each word SHALL be sent MSB first: [31:24], [23:16], [15:8], [7:0].
REQ-017 FSM states: IDLE, SOF, FETCH, DATA, EOF, PAD, DONE.
REQ-018 Transitions:
  - IDLE->SOF on start_i.
  - SOF->FETCH if word_cnt>0, else SOF->EOF.
  - FETCH->DATA after 1 cycle.
  - DATA->FETCH after byte 3 if words remain, else DATA->EOF.
  - EOF->PAD.
  - PAD->DONE.
  - DONE->IDLE after 1 cycle.
REQ-019 Per byte, byte_o SHALL be driven first, then byte_stb_o high for STB_HI cycles, then low for STB_LO cycles.
REQ-020 The FETCH cycle SHALL drive rd_addr_o = word index with byte_stb_o=0; rd_data_i SHALL be captured into a 32-bit shift register at FETCH exit.
REQ-021 Word index SHALL start at 0, increment by 1 per fetched word, and never wrap within a frame; word_cnt=2^ADDR_W SHALL send addresses 0..2^ADDR_W-1.
REQ-022 Total frame length SHALL be (3+4N)*(STB_HI+STB_LO)+N cycles from the first SOF cycle, where N = word_cnt.
REQ-023 busy_o SHALL rise in the cycle after start_i is sampled and fall in the DONE cycle; done_o SHALL pulse in DONE.
REQ-024 A start_i asserted while busy_o=1, including in the DONE cycle, SHALL be ignored with no side effects.
REQ-025 In IDLE, byte_stb_o SHALL be 0 and byte_o SHALL be 0x00.

Reset
REQ-026 Asserting reset_n low SHALL immediately force IDLE with byte_o=0, byte_stb_o=0, rd_addr_o=0, busy_o=0, done_o=0, err_o=0, and clear all counters and the shift register.
REQ-027 A reset during a frame SHALL abort it with no EOF or PAD sent; the next start_i after deassertion SHALL begin a fresh frame at SOF.

Configuration
REQ-028 Macro IMEM_TX_FF_CHECK_EN.
  - Defined: each fetched word is checked before its first byte is sent. If any byte equals 0xFF, no byte of that word is sent; the FSM goes to EOF, sends EOF and PAD, and pulses err_o (not done_o) in the final cycle.
  - Not defined: data bytes are sent verbatim, err_o is tied 0, and the check logic is absent.

Structure
REQ-029 Shared package imem_stream_pkg SHALL hold SOF=8'hFE, EOF=8'hFF, PAD=8'h00 and the FSM state enum, shared with the loader side.
REQ-030 The strobe timing (high/low phase counter, byte_done pulse) SHALL be the sub-module imem_tx_strobe_gen, parameterised by STB_HI and STB_LO.

Verification
REQ-031 Empty frame: word_cnt=0, start -> byte sequence FE,FF,00; 3 strobes; done_o after 12 cycles; rd_addr_o never changes.
REQ-032 One word: buffer[0]=0x12345678, word_cnt=1 -> FE,12,34,56,78,FF,00; done_o after 29 cycles.
REQ-033 Full buffer: ADDR_W=6, word_cnt=64 with buffer[i]=i -> rd_addr_o sweeps 0..63 with no wrap; 259 strobes; a loader model reconstructs all 64 words.
REQ-034 Reset mid-frame: assert reset_n low during word 2 byte 1 -> all outputs 0 in the same cycle; a restart sends a complete frame.
REQ-035 Start while busy: pulse start_i during DATA -> frame unchanged, exactly one done_o.
REQ-036 With IMEM_TX_FF_CHECK_EN: buffer[1]=0x00FF0000, word_cnt=3 -> FE, word0 bytes, FF, 00; err_o pulses once; done_o never pulses.
